// File: rtl/lv_owt_adc_poll_sched.sv
// Periodic watchdog ADC-poll scheduler for the LV one-wire link: issues ADC read
// requests at a programmable period, defers behind SPI traffic, retries on timeout/CRC error.
module lv_owt_adc_poll_sched #(
  parameter int PERIOD_W = 16,
  parameter int TMO_W    = 12,
  parameter int RETRY_W  = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_poll_en,
  input  logic [PERIOD_W-1:0] i_poll_period,
  input  logic [TMO_W-1:0]    i_rsp_tmo,
  input  logic [RETRY_W-1:0]  i_max_retry,
  input  logic                i_spi_busy,
  output logic                o_wdg_owt_adc_req,
  input  logic                i_owt_wdg_adc_ack,
  input  logic                i_owt_rx_adc_vld,
  input  logic                i_owt_rx_adc_crc_err,
  output logic                o_adc_poll_done,
  output logic                o_adc_poll_fail,
  output logic                o_poll_overrun,
  output logic [RETRY_W-1:0]  o_retry_cnt,
  output logic                o_poll_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_REQ  = 2'd2,
    S_RSP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, per_last;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d, tmo_last;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                pend_q, pend_d;
  logic                req_q, busy_q;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                ovr_q, ovr_d;
  logic                tick, take, rsp_good, rsp_bad;

  // A programmed value of 0 behaves like 1, so the terminal count saturates at 0.
  assign per_last = (i_poll_period == '0) ? '0 : i_poll_period - 1'b1;
  assign tmo_last = (i_rsp_tmo == '0) ? '0 : i_rsp_tmo - 1'b1;

  assign tick = i_poll_en & (per_cnt_q == per_last);

  always_comb begin
    per_cnt_d = per_cnt_q + 1'b1;
    if (!i_poll_en || tick) per_cnt_d = '0;
  end

  // A tick is consumed only when it launches a poll straight out of ARM.
  assign take  = (state_q == S_ARM) & i_poll_en & ~i_spi_busy & (tick | pend_q);
  assign ovr_d = tick & pend_q & ~take;

  always_comb begin
    pend_d = pend_q;
    if (take)      pend_d = 1'b0;
    else if (tick) pend_d = 1'b1;
  end

  // A response in the timeout cycle wins over the timeout.
  assign rsp_good = i_owt_rx_adc_vld & ~i_owt_rx_adc_crc_err;
  assign rsp_bad  = (i_owt_rx_adc_vld & i_owt_rx_adc_crc_err) |
                    (~i_owt_rx_adc_vld & (tmo_cnt_q == tmo_last));

  // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    tmo_cnt_d = tmo_cnt_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_poll_en) state_d = S_ARM;
      end
      S_ARM: begin
        if (!i_poll_en) begin
          state_d = S_IDLE;
        end else if (take) begin
          state_d = S_REQ;
          retry_d = '0;
        end
      end
      S_REQ: begin
        // No timeout here: an SPI preemption of the TX frame only delays the ack.
        if (i_owt_wdg_adc_ack) begin
          state_d   = S_RSP;
          tmo_cnt_d = '0;
        end
      end
      S_RSP: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (rsp_good) begin
          done_d  = 1'b1;
          retry_d = '0;
          state_d = i_poll_en ? S_ARM : S_IDLE;
        end else if (rsp_bad) begin
          if (retry_q == i_max_retry) begin
            fail_d  = 1'b1;
            retry_d = '0;
            state_d = i_poll_en ? S_ARM : S_IDLE;
          end else if (i_poll_en) begin
            retry_d = retry_q + 1'b1;
            state_d = S_REQ;
          end else begin
            // Polling was disabled mid-poll: abandon quietly instead of retrying.
            retry_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
      retry_q   <= '0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      retry_q   <= retry_d;
      pend_q    <= pend_d;
      req_q     <= (state_d == S_REQ);
      busy_q    <= (state_d == S_REQ) || (state_d == S_RSP);
      done_q    <= done_d;
      fail_q    <= fail_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_wdg_owt_adc_req = req_q;
  assign o_poll_busy       = busy_q;
  assign o_adc_poll_done   = done_q;
  assign o_adc_poll_fail   = fail_q;
  assign o_poll_overrun    = ovr_q;
  assign o_retry_cnt       = retry_q;

endmodule

// File: tb/tb_lv_owt_adc_poll_sched.sv
// Self-checking bench for lv_owt_adc_poll_sched: phase-level reference model compared
// every cycle, plus directed scenarios with hand-computed cycle counts.
module tb_lv_owt_adc_poll_sched;

  logic        clk;
  logic        rst_n;
  logic        poll_en;
  logic [15:0] poll_period;
  logic [11:0] rsp_tmo;
  logic [2:0]  max_retry;
  logic        spi_busy;
  logic        ack;
  logic        vld;
  logic        crc;
  logic        req, done, fail, ovr, pbusy;
  logic [2:0]  retry;

  int checks = 0;
  int errors = 0;
  int cnt_done = 0;
  int cnt_fail = 0;
  int cnt_ovr  = 0;

  lv_owt_adc_poll_sched dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_poll_en            (poll_en),
    .i_poll_period        (poll_period),
    .i_rsp_tmo            (rsp_tmo),
    .i_max_retry          (max_retry),
    .i_spi_busy           (spi_busy),
    .o_wdg_owt_adc_req    (req),
    .i_owt_wdg_adc_ack    (ack),
    .i_owt_rx_adc_vld     (vld),
    .i_owt_rx_adc_crc_err (crc),
    .o_adc_poll_done      (done),
    .o_adc_poll_fail      (fail),
    .o_poll_overrun       (ovr),
    .o_retry_cnt          (retry),
    .o_poll_busy          (pbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model, evaluated on the falling edge ----------------
  typedef enum {PH_IDLE, PH_ARM, PH_REQ, PH_RSP} phase_t;

  initial begin
    phase_t ph;
    int     age, tries, waited, p, t;
    bit     pend, tk, took, good, bad;
    bit     e_req, e_busy, e_done, e_fail, e_ovr;
    int     e_retry;
    ph = PH_IDLE; age = 0; tries = 0; waited = 0; pend = 0;
    e_req = 0; e_busy = 0; e_done = 0; e_fail = 0; e_ovr = 0; e_retry = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = PH_IDLE; age = 0; tries = 0; waited = 0; pend = 0;
        e_req = 0; e_busy = 0; e_done = 0; e_fail = 0; e_ovr = 0; e_retry = 0;
      end
      check("req",      int'(req),   int'(e_req));
      check("busy",     int'(pbusy), int'(e_busy));
      check("done",     int'(done),  int'(e_done));
      check("fail",     int'(fail),  int'(e_fail));
      check("overrun",  int'(ovr),   int'(e_ovr));
      check("retry",    int'(retry), e_retry);
      cnt_done += int'(done);
      cnt_fail += int'(fail);
      cnt_ovr  += int'(ovr);
      if (rst_n) begin
        // Predict what the next rising edge produces from the inputs held now.
        p    = (poll_period == 0) ? 1 : int'(poll_period);
        t    = (rsp_tmo == 0) ? 1 : int'(rsp_tmo);
        tk   = poll_en && ((age % p) == p - 1);
        age  = poll_en ? age + 1 : 0;
        took = (ph == PH_ARM) && poll_en && !spi_busy && (tk || pend);
        e_ovr  = tk && pend && !took;
        e_done = 0;
        e_fail = 0;
        if (took)    pend = 0;
        else if (tk) pend = 1;
        case (ph)
          PH_IDLE: if (poll_en) ph = PH_ARM;
          PH_ARM: begin
            if (!poll_en) ph = PH_IDLE;
            else if (took) begin ph = PH_REQ; tries = 0; end
          end
          PH_REQ: if (ack) begin ph = PH_RSP; waited = 0; end
          PH_RSP: begin
            good = vld && !crc;
            bad  = (vld && crc) || (!vld && waited == t - 1);
            waited++;
            if (good) begin
              e_done = 1; tries = 0; ph = poll_en ? PH_ARM : PH_IDLE;
            end else if (bad) begin
              if (tries == int'(max_retry)) begin
                e_fail = 1; tries = 0; ph = poll_en ? PH_ARM : PH_IDLE;
              end else if (poll_en) begin
                tries++; ph = PH_REQ;
              end else begin
                tries = 0; ph = PH_IDLE;
              end
            end
          end
          default: ph = PH_IDLE;
        endcase
        e_req   = (ph == PH_REQ);
        e_busy  = (ph == PH_REQ) || (ph == PH_RSP);
        e_retry = tries;
      end
    end
  end

  // ---------------- stimulus helpers (inputs change 1 time unit after the rising edge) -------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; poll_en = 1'b0; spi_busy = 1'b0;
    ack = 1'b0; vld = 1'b0; crc = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic pulse_vld(input bit bad);
    vld = 1'b1;
    crc = bad;
    step(1);
    vld = 1'b0;
    crc = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (req !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    check("req_seen", int'(req), 1);
  endtask

  initial begin
    int n, base_d, base_f, base_o;
    rst_n = 1'b0; poll_en = 1'b0; spi_busy = 1'b0;
    ack = 1'b0; vld = 1'b0; crc = 1'b0;
    poll_period = 16'd100; rsp_tmo = 12'd50; max_retry = 3'd2;
    step(1);
    check("rst_req",   int'(req),   0);
    check("rst_busy",  int'(pbusy), 0);
    check("rst_retry", int'(retry), 0);

    // 1: period 100, good response 20 cycles after ack, spurious ack/vld in ARM.
    do_reset();
    poll_period = 16'd100; rsp_tmo = 12'd50; max_retry = 3'd2;
    base_d = cnt_done;
    poll_en = 1'b1;
    wait_req(200, n);
    check("s1_first_req_cycle", n, 100);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_req(200, n);
        check("s1_req_spacing", n, 70);
      end
      check("s1_retry_at_req", int'(retry), 0);
      step(2);
      pulse_ack();
      check("s1_req_drop", int'(req), 0);
      step(19);
      pulse_vld(1'b0);
      check("s1_done_pulse", int'(done), 1);
      step(1);
      check("s1_done_width", int'(done), 0);
      check("s1_back_in_arm", int'(pbusy), 0);
      step(4);
      pulse_ack();
      pulse_vld(1'b0);
    end
    step(2);
    check("s1_done_count", cnt_done - base_d, 3);

    // 2: no response, retry limit 2 -> three attempts then one fail pulse.
    do_reset();
    poll_period = 16'd1000; rsp_tmo = 12'd50; max_retry = 3'd2;
    base_f = cnt_fail;
    poll_en = 1'b1;
    wait_req(1100, n);
    check("s2_first_req_cycle", n, 1000);
    for (int a = 0; a < 3; a++) begin
      step(1);
      pulse_ack();
      check("s2_req_drop", int'(req), 0);
      if (a < 2) begin
        wait_req(100, n);
        check("s2_timeout_cycles", n, 50);
        check("s2_retry_cnt", int'(retry), a + 1);
      end else begin
        step(49);
        check("s2_no_early_fail", int'(fail), 0);
        step(1);
        check("s2_fail_pulse", int'(fail), 1);
        check("s2_arm_after_fail", int'(pbusy), 0);
        check("s2_retry_cleared", int'(retry), 0);
        step(1);
        check("s2_fail_width", int'(fail), 0);
      end
    end
    step(2);
    check("s2_fail_count", cnt_fail - base_f, 1);

    // 3: CRC error first, good response second.
    do_reset();
    poll_period = 16'd1000; rsp_tmo = 12'd50; max_retry = 3'd2;
    base_f = cnt_fail;
    poll_en = 1'b1;
    wait_req(1100, n);
    step(1);
    pulse_ack();
    step(9);
    pulse_vld(1'b1);
    check("s3_retry_req", int'(req), 1);
    check("s3_retry_cnt", int'(retry), 1);
    step(1);
    pulse_ack();
    step(9);
    pulse_vld(1'b0);
    check("s3_done", int'(done), 1);
    check("s3_retry_cleared", int'(retry), 0);
    step(2);
    check("s3_no_fail", cnt_fail - base_f, 0);

    // 4: SPI busy across two ticks (period 20): one overrun, request right after busy falls.
    do_reset();
    poll_period = 16'd20; rsp_tmo = 12'd50; max_retry = 3'd2;
    base_o = cnt_ovr;
    poll_en = 1'b1;
    step(15);
    spi_busy = 1'b1;
    step(30);
    check("s4_held_off", int'(req), 0);
    check("s4_overrun_count", cnt_ovr - base_o, 1);
    spi_busy = 1'b0;
    step(1);
    check("s4_req_after_busy", int'(req), 1);
    step(3);
    pulse_ack();
    step(2);
    pulse_vld(1'b0);
    step(3);

    // 5: enable dropped in RSP, timeout with retries left -> no fail, no retry, IDLE.
    do_reset();
    poll_period = 16'd100; rsp_tmo = 12'd50; max_retry = 3'd2;
    base_d = cnt_done; base_f = cnt_fail;
    poll_en = 1'b1;
    wait_req(200, n);
    step(1);
    pulse_ack();
    step(5);
    poll_en = 1'b0;
    step(45);
    check("s5_idle_busy", int'(pbusy), 0);
    check("s5_no_retry", int'(req), 0);
    step(10);
    check("s5_still_no_req", int'(req), 0);
    check("s5_no_fail", cnt_fail - base_f, 0);
    check("s5_no_done", cnt_done - base_d, 0);
    poll_en = 1'b1;
    wait_req(200, n);
    check("s5_restart_from_zero", n, 100);

    // 6: period 0 / tmo 0, overrun while busy polling, async reset during REQ.
    do_reset();
    poll_period = 16'd0; rsp_tmo = 12'd0; max_retry = 3'd1;
    poll_en = 1'b1;
    wait_req(10, n);
    check("s6_first_req_cycle", n, 2);
    step(3);
    check("s6_overrun_in_req", int'(ovr), 1);
    pulse_ack();
    step(1);
    check("s6_one_cycle_timeout_retry", int'(req), 1);
    check("s6_retry_cnt", int'(retry), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_req_drop", int'(req), 0);
    check("s6_async_busy_clear", int'(pbusy), 0);
    check("s6_async_retry_clear", int'(retry), 0);
    step(2);
    rst_n = 1'b1;
    poll_en = 1'b0;
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
